mult_sched: RTL and testbench

Two-requester scheduler for the shared 32x32 iterative multiplier (`multiply`: `clk`, `mult_begin`, `mult_op1`, `mult_op2`, `product[63:0]`, `mult_end`). Accepts operand pairs from two clients over valid/ready handshakes and arbitrates round-robin. Sequences `mult_begin` over the multiplier's level protocol, guards each operation with a timeout watchdog, and returns the 64-bit product to the granted client through a held response handshake. Sits between the multiplier and its two users (e.g. the ALU issue stage and a test/DMA port).

---
 rtl/mult_sched_if.sv | 32 +++
 rtl/mult_sched.sv | 110 +++++++++++
 tb/tb_mult_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_sched_if.sv
// Client handshakes, response path and multiplier bus of the shared-multiplier scheduler.
// The scheduler takes the slave view; clients plus the multiplier take the master view.
interface mult_sched_if #(
  parameter int CW = 8
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [31:0]   req0_op1;
  logic [31:0]   req0_op2;
  logic [31:0]   req1_op1;
  logic [31:0]   req1_op2;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [63:0]   rsp_product;
  logic          rsp_err;
  logic [CW-1:0] last_latency;
  logic          mult_begin;
  logic [31:0]   mult_op1;
  logic [31:0]   mult_op2;
  logic [63:0]   product;
  logic          mult_end;

  modport slave (
    input  req_valid, req0_op1, req0_op2, req1_op1, req1_op2, rsp_ready, product, mult_end,
    output req_ready, rsp_valid, rsp_product, rsp_err, last_latency, mult_begin, mult_op1, mult_op2
  );

  modport master (
    output req_valid, req0_op1, req0_op2, req1_op1, req1_op2, rsp_ready, product, mult_end,
    input  req_ready, rsp_valid, rsp_product, rsp_err, last_latency, mult_begin, mult_op1, mult_op2
  );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler for two clients sharing one iterative 32x32 multiplier,
// with a timeout watchdog per operation and a held response handshake.
module mult_sched #(
  parameter int TIMEOUT = 40,
  parameter int CW      = 8
) (
  input logic       clk,
  input logic       reset,
  mult_sched_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int          WW      = $clog2(TIMEOUT + 1);
  localparam logic [31:0] LAT_MAX = 32'((64'd1 << CW) - 64'd1);

  logic [1:0]    state;
  logic          owner;
  logic          last_grant;
  logic [WW-1:0] wdog;
  logic          grant;
  logic [1:0]    req_ready;
  logic          fire;
  logic          wd_expired;
  logic [31:0]   mult_op1;
  logic [31:0]   mult_op2;
  logic [63:0]   rsp_product;
  logic          rsp_err;
  logic [CW-1:0] last_latency;

  function automatic logic [CW-1:0] sat_lat(input logic [31:0] v);
    if (v > LAT_MAX) return LAT_MAX[CW-1:0];
    return v[CW-1:0];
  endfunction

  // A tie goes to the client that was not served last.
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
    req_ready = 2'b00;
    if (state == IDLE && !reset)
      req_ready = grant ? {bus.req_valid[1], 1'b0} : {1'b0, bus.req_valid[0]};
  end

  assign fire       = |req_ready;
  assign wd_expired = (wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      wdog         <= '0;
      mult_op1     <= '0;
      mult_op2     <= '0;
      rsp_product  <= '0;
      rsp_err      <= 1'b0;
      last_latency <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            mult_op1   <= grant ? bus.req1_op1 : bus.req0_op1;
            mult_op2   <= grant ? bus.req1_op2 : bus.req0_op2;
            owner      <= grant;
            last_grant <= grant;
            wdog       <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // A completion in the expiry cycle still counts as a good result.
          if (bus.mult_end) begin
            rsp_product  <= bus.product;
            rsp_err      <= 1'b0;
            last_latency <= sat_lat(32'(wdog) + 32'd1);
            state        <= RESP;
          end else if (wd_expired) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            state       <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.mult_begin   = (state == BUSY);
  assign bus.rsp_valid    = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.mult_op1     = mult_op1;
  assign bus.mult_op2     = mult_op2;
  assign bus.rsp_product  = rsp_product;
  assign bus.rsp_err      = rsp_err;
  assign bus.last_latency = last_latency;

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: behavioural multiplier, directed scenarios and random traffic,
// all outputs compared every cycle against a timestamp-based transaction model.
module tb_mult_sched;
  localparam int TIMEOUT = 40;
  localparam int CW      = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_sched_if #(.CW(CW)) bus();

  mult_sched #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // stimulus knobs
  bit auto_mode = 0;
  bit stub      = 0;
  bit noise     = 0;
  int lat_lo    = 33;
  int lat_hi    = 33;
  int p_req     = 0;
  int p_rdy     = 100;
  int mb_cnt    = 0;
  int target    = 33;

  // reference model: one outstanding operation described by timestamps
  bit            have_op = 0;
  bit            m_done  = 0;
  bit            m_own   = 0;
  bit            m_lg    = 1;
  bit            m_err   = 0;
  logic [31:0]   m_op1, m_op2;
  logic [63:0]   m_prod;
  int            m_fire  = 0;
  logic [CW-1:0] m_lat   = '0;

  // observations of the DUT used by the directed scenarios
  logic [1:0]  acc = 2'b00;
  int          rsp_cnt = 0;
  int          dut_fire = 0;
  int          dut_rsp_cyc = 0;
  logic [63:0] cap_prod;
  logic        cap_err;
  logic [1:0]  cap_rv;
  bit          rv_prev = 0, mb_prev = 0, mb_seen = 0;
  int          rv_run = 0, rv_len = 0, mb_run = 0, mb_len = 0, lo_run = 0;
  logic [63:0] rsp_log[$];
  bit          grant_log[$];
  int          gap_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(3, 0))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_cycle();
    logic       exp_mb;
    logic [1:0] exp_rv, exp_rr;
    logic       g;
    int         k;
    if (reset) begin
      have_op = 0; m_lg = 1; m_lat = '0; acc = 2'b00;
      rv_prev = 0; mb_prev = 0; mb_seen = 0; lo_run = 0;
      chk("rst_mult_begin", bus.mult_begin, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_req_ready", bus.req_ready, 0);
    end else begin
      exp_mb = have_op && !m_done && (cyc > m_fire);
      exp_rv = (have_op && m_done) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      g      = (bus.req_valid == 2'b11) ? ~m_lg : bus.req_valid[1];
      exp_rr = 2'b00;
      if (!have_op && bus.req_valid != 2'b00) exp_rr = g ? 2'b10 : 2'b01;

      chk("mult_begin", bus.mult_begin, exp_mb);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      chk("req_ready", bus.req_ready, exp_rr);
      chk("last_latency", bus.last_latency, m_lat);
      if (exp_mb) begin
        chk("mult_op1", bus.mult_op1, m_op1);
        chk("mult_op2", bus.mult_op2, m_op2);
      end
      if (exp_rv != 2'b00) begin
        chk("rsp_product", bus.rsp_product, m_prod);
        chk("rsp_err", bus.rsp_err, m_err);
      end

      acc = bus.req_valid & bus.req_ready;
      if (|acc) begin
        dut_fire = cyc;
        grant_log.push_back(acc[1]);
      end
      if (|bus.rsp_valid && !rv_prev) begin
        rsp_cnt++;
        dut_rsp_cyc = cyc;
        cap_prod = bus.rsp_product;
        cap_err  = bus.rsp_err;
        cap_rv   = bus.rsp_valid;
        rsp_log.push_back(bus.rsp_product);
        rv_run = 0;
      end
      if (|bus.rsp_valid) rv_run++;
      else if (rv_prev) rv_len = rv_run;
      rv_prev = |bus.rsp_valid;
      if (bus.mult_begin) begin
        if (!mb_prev) begin
          if (mb_seen) gap_log.push_back(lo_run);
          mb_run = 0;
        end
        mb_run++;
      end else begin
        if (mb_prev) begin
          mb_len = mb_run; lo_run = 0; mb_seen = 1;
        end
        lo_run++;
      end
      mb_prev = bus.mult_begin;

      // advance the model to what the coming clock edge must do
      if (!have_op) begin
        if (exp_rr != 2'b00) begin
          have_op = 1; m_done = 0; m_own = g; m_lg = g; m_fire = cyc;
          m_op1 = g ? bus.req1_op1 : bus.req0_op1;
          m_op2 = g ? bus.req1_op2 : bus.req0_op2;
        end
      end else if (!m_done) begin
        if (cyc > m_fire) begin
          k = cyc - m_fire;
          if (bus.mult_end) begin
            m_done = 1; m_err = 0;
            m_prod = 64'(m_op1) * 64'(m_op2);
            m_lat  = (k >= (1 << CW)) ? {CW{1'b1}} : CW'(k);
          end else if (k == TIMEOUT) begin
            m_done = 1; m_err = 1; m_prod = 64'h0;
          end
        end
      end else if (bus.rsp_ready[m_own]) begin
        have_op = 0;
      end
    end
  endtask

  task automatic drive_clients();
    logic [31:0] a, b;
    for (int i = 0; i < 2; i++) begin
      if (!bus.req_valid[i] || acc[i]) begin
        bus.req_valid[i] = ($urandom_range(99, 0) < p_req);
        a = rnd32();
        b = rnd32();
        if (i == 0) begin bus.req0_op1 = a; bus.req0_op2 = b; end
        else        begin bus.req1_op1 = a; bus.req1_op2 = b; end
      end
      bus.rsp_ready[i] = ($urandom_range(99, 0) < p_rdy);
    end
  endtask

  // One cycle: check at the falling edge, then update multiplier and clients after the rising edge.
  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
    if (bus.mult_begin) begin
      mb_cnt++;
      if (mb_cnt == 1) target = $urandom_range(lat_hi, lat_lo);
    end else begin
      mb_cnt = 0;
    end
    bus.mult_end = 1'b0;
    bus.product  = {$urandom, $urandom};
    if (bus.mult_begin && !stub && mb_cnt == target) begin
      bus.mult_end = 1'b1;
      bus.product  = 64'(bus.mult_op1) * 64'(bus.mult_op2);
    end else if (!bus.mult_begin && noise && $urandom_range(3, 0) == 0) begin
      bus.mult_end = 1'b1;
    end
    if (auto_mode) drive_clients();
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    bit got = 0;
    if (i == 0) begin bus.req0_op1 = a; bus.req0_op2 = b; end
    else        begin bus.req1_op1 = a; bus.req1_op2 = b; end
    bus.req_valid[i] = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      step();
      got = acc[i];
    end
    bus.req_valid[i] = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int n0, input int want);
    for (int n = 0; n < 400 && rsp_cnt < n0 + want; n++) step();
    if (rsp_cnt < n0 + want) chk("response_timeout", rsp_cnt - n0, want);
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (!bus.mult_begin && bus.rsp_valid == 2'b00) break;
      step();
    end
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, gs, ls;
    reset = 1'b1;
    bus.req_valid = 2'b11;
    bus.req0_op1 = 32'h5; bus.req0_op2 = 32'h6;
    bus.req1_op1 = 32'h7; bus.req1_op2 = 32'h8;
    bus.rsp_ready = 2'b00;
    bus.product = 64'h0;
    bus.mult_end = 1'b0;
    repeat (3) step();
    chk("reset_mult_op1", bus.mult_op1, 0);
    chk("reset_mult_op2", bus.mult_op2, 0);
    chk("reset_rsp_product", bus.rsp_product, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_last_latency", bus.last_latency, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    bus.req_valid = 2'b00;
    reset = 1'b0;
    step();

    // single client-0 operation, response consumed immediately
    lat_lo = 33; lat_hi = 33; bus.rsp_ready = 2'b11;
    n0 = rsp_cnt;
    issue(0, 32'h1111_1111, 32'h2222_2222);
    wait_rsp(n0, 1);
    step(); step();
    chk("p1_product", cap_prod, 64'h0246_8ACF_0ECA_8642);
    chk("p1_err", cap_err, 0);
    chk("p1_rsp_owner", cap_rv, 2'b01);
    chk("p1_rsp_len", rv_len, 1);
    chk("p1_begin_len", mb_len, 33);
    chk("p1_accept_to_rsp", dut_rsp_cyc - dut_fire, 34);
    chk("p1_last_latency", bus.last_latency, 33);
    drain();

    // simultaneous requests right after reset
    reset = 1'b1; step(); step(); reset = 1'b0;
    lat_lo = 5; lat_hi = 10;
    ls = rsp_log.size(); gs = grant_log.size(); n0 = rsp_cnt;
    bus.req0_op1 = 32'd3; bus.req0_op2 = 32'd5;
    bus.req1_op1 = 32'h7FFF_FFFF; bus.req1_op2 = 32'd2;
    bus.req_valid = 2'b11;
    for (int n = 0; n < 400 && rsp_cnt < n0 + 2; n++) begin
      step();
      if (acc[0]) bus.req_valid[0] = 1'b0;
      if (acc[1]) bus.req_valid[1] = 1'b0;
    end
    bus.req_valid = 2'b00;
    chk("p2_rsp_count", rsp_cnt - n0, 2);
    if (rsp_log.size() >= ls + 2) begin
      chk("p2_first_product", rsp_log[ls], 64'hF);
      chk("p2_second_product", rsp_log[ls + 1], 64'hFFFF_FFFE);
      chk("p2_first_grant", grant_log[gs], 0);
      chk("p2_second_grant", grant_log[gs + 1], 1);
    end
    drain();

    // back-to-back contention, both clients always valid
    lat_lo = 1; lat_hi = 36;
    gs = grant_log.size(); ls = gap_log.size(); n0 = rsp_cnt;
    bus.req0_op1 = $urandom; bus.req0_op2 = $urandom;
    bus.req1_op1 = $urandom; bus.req1_op2 = $urandom;
    bus.req_valid = 2'b11;
    for (int n = 0; n < 600 && rsp_cnt < n0 + 4; n++) begin
      step();
      if (acc[0]) begin bus.req0_op1 = $urandom; bus.req0_op2 = $urandom; end
      if (acc[1]) begin bus.req1_op1 = $urandom; bus.req1_op2 = $urandom; end
    end
    bus.req_valid = 2'b00;
    chk("p3_grant_count", grant_log.size() - gs, 4);
    chk("p3_gap_count", gap_log.size() - ls, 4);
    if (grant_log.size() >= gs + 4 && gap_log.size() >= ls + 4) begin
      for (int k = 0; k < 4; k++) chk("p3_grant_order", grant_log[gs + k], k % 2);
      for (int k = 1; k < 4; k++) chk("p3_begin_gap", gap_log[ls + k], 2);
    end
    drain();

    // client 1 withholds rsp_ready for 10 cycles while client 0 waits
    lat_lo = 8; lat_hi = 8; bus.rsp_ready = 2'b01;
    n0 = rsp_cnt;
    issue(1, 32'h0001_0000, 32'h0001_0000);
    bus.req0_op1 = 32'd9; bus.req0_op2 = 32'd9; bus.req_valid[0] = 1'b1;
    wait_rsp(n0, 1);
    repeat (10) step();
    chk("p4_rsp_valid_held", bus.rsp_valid, 2'b10);
    chk("p4_product_held", bus.rsp_product, 64'h1_0000_0000);
    chk("p4_req_ready", bus.req_ready, 0);
    chk("p4_mult_begin", bus.mult_begin, 0);
    bus.rsp_ready = 2'b11;
    n0 = rsp_cnt;
    for (int n = 0; n < 100 && !acc[0]; n++) step();
    bus.req_valid = 2'b00;
    wait_rsp(n0, 1);
    chk("p4_client0_product", cap_prod, 64'd81);
    drain();

    // completion arriving in the watchdog's final cycle
    lat_lo = 40; lat_hi = 40;
    n0 = rsp_cnt;
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(n0, 1);
    chk("tie_product", cap_prod, 64'hFFFF_FFFE_0000_0001);
    chk("tie_err", cap_err, 0);
    chk("tie_accept_to_rsp", dut_rsp_cyc - dut_fire, 41);
    chk("tie_last_latency", bus.last_latency, 40);
    drain();

    // multiplier never completes
    stub = 1;
    n0 = rsp_cnt;
    issue(0, 32'd12, 32'd12);
    wait_rsp(n0, 1);
    step(); step();
    chk("to_accept_to_rsp", dut_rsp_cyc - dut_fire, 41);
    chk("to_err", cap_err, 1);
    chk("to_product", cap_prod, 0);
    chk("to_begin_len", mb_len, 40);
    chk("to_last_latency_kept", bus.last_latency, 40);
    chk("to_begin_low_after", bus.mult_begin, 0);
    stub = 0;
    drain();

    // reset five cycles into BUSY
    lat_lo = 33; lat_hi = 33;
    issue(0, 32'd100, 32'd100);
    repeat (4) step();
    chk("mid_begin_before_reset", bus.mult_begin, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_async_mult_begin", bus.mult_begin, 0);
    chk("mid_async_rsp_valid", bus.rsp_valid, 0);
    chk("mid_async_req_ready", bus.req_ready, 0);
    step(); step();
    reset = 1'b0;
    chk("mid_after_last_latency", bus.last_latency, 0);
    n0 = rsp_cnt;
    issue(0, 32'd6, 32'd7);
    wait_rsp(n0, 1);
    chk("mid_reissue_product", cap_prod, 64'd42);
    chk("mid_reissue_err", cap_err, 0);
    drain();

    // random traffic with spurious mult_end outside BUSY and occasional timeouts
    n0 = rsp_cnt;
    auto_mode = 1; noise = 1; lat_lo = 1; lat_hi = 45; p_req = 70; p_rdy = 60;
    repeat (3000) step();
    p_req = 0; p_rdy = 100;
    repeat (300) step();
    auto_mode = 0; noise = 0;
    chk("rand_progress", (rsp_cnt - n0) > 20, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
